// File: rtl/riscv_mc_pkg.sv
// Shared types for the multi-cycle RISC-V control sequencer.
// Holds the state encoding, opcode map, mux-select encodings and the strobe bundle.
package riscv_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_IMM = 2'b01;
  localparam logic [1:0] NPC_ALU = 2'b10;

  localparam logic [1:0] WD_NONE = 2'b00;
  localparam logic [1:0] WD_ALU  = 2'b01;
  localparam logic [1:0] WD_MEM  = 2'b10;
  localparam logic [1:0] WD_PC   = 2'b11;

  typedef enum logic [3:0] {
    C_R, C_IMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
  } op_class_e;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_wr;
    logic       ir_wr;
    logic       rf_wr;
    logic       asel;
    logic       bsel;
    logic [1:0] npc_sel;
    logic [1:0] wd_sel;
  } ctrl_t;

  function automatic op_class_e classify(input logic [6:0] op);
    case (op)
      OP_R:      classify = C_R;
      OP_IMM:    classify = C_IMM;
      OP_LOAD:   classify = C_LOAD;
      OP_STORE:  classify = C_STORE;
      OP_BRANCH: classify = C_BRANCH;
      OP_JAL:    classify = C_JAL;
      OP_JALR:   classify = C_JALR;
      OP_LUI:    classify = C_LUI;
      OP_AUIPC:  classify = C_AUIPC;
      default:   classify = C_BAD;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_sequencer_if.sv
// Instruction/data memory request-acknowledge handshake between sequencer and memories.
interface riscv_mc_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/riscv_mc_wait_timer.sv
// Counts request cycles that go unacknowledged; expired flags the MAX_WAIT-th such cycle.
module riscv_mc_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  logic [CW-1:0] cnt;

  // Combinational so the caller can still let a same-cycle ack take priority.
  assign expired = enable && (cnt == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (enable && !expired) cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/riscv_mc_sequencer.sv
// Multi-cycle RISC-V control FSM: fetch/decode/exec/mem/writeback with memory timeouts,
// a sticky error state and a retired-instruction counter.
module riscv_mc_sequencer
  import riscv_mc_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              opcode,
  input  logic [2:0]              func3,
  input  logic                    zero,
  riscv_mc_sequencer_if.master    bus,
  output logic                    pc_wr,
  output logic                    ir_wr,
  output logic                    rf_wr,
  output logic                    asel,
  output logic                    bsel,
  output logic [1:0]              npc_sel,
  output logic [1:0]              wd_sel,
  output logic                    err,
  output logic [2:0]              state,
  output logic [CNT_W-1:0]        instret
);
  state_e    st, st_nxt;
  op_class_e cls;
  ctrl_t     c;
  logic      req, ack, expired, taken, retire;
  logic      unused_f3;

  assign cls       = classify(opcode);
  assign taken     = zero ^ func3[0];
  assign unused_f3 = ^func3[2:1];

  // Acks only count while the matching request is actually being driven.
  assign req = (st == ST_FETCH) || (st == ST_MEM);
  assign ack = ((st == ST_FETCH) && bus.imem_ack) || ((st == ST_MEM) && bus.dmem_ack);

  riscv_mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (st_nxt != st),
    .enable  (req && !ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= ST_IDLE;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:   st_nxt = ST_FETCH;
      ST_FETCH: begin
        if (ack)          st_nxt = ST_DECODE;
        else if (expired) st_nxt = ST_ERR;
      end
      ST_DECODE: st_nxt = (cls == C_BAD) ? ST_ERR : ST_EXEC;
      ST_EXEC: begin
        case (cls)
          C_BRANCH:         st_nxt = ST_FETCH;
          C_LOAD, C_STORE:  st_nxt = ST_MEM;
          C_BAD:            st_nxt = ST_ERR;
          default:          st_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (ack)          st_nxt = (cls == C_STORE) ? ST_FETCH : ST_WB;
        else if (expired) st_nxt = ST_ERR;
      end
      ST_WB:     st_nxt = ST_FETCH;
      default:   st_nxt = ST_ERR;
    endcase
  end

  always_comb begin
    c = '0;
    case (st)
      ST_FETCH: begin
        c.imem_req = 1'b1;
        if (ack) begin
          c.ir_wr   = 1'b1;
          c.pc_wr   = 1'b1;
          c.npc_sel = NPC_PC4;
        end
      end
      ST_EXEC: begin
        c.asel = (cls == C_BRANCH) || (cls == C_JAL) || (cls == C_AUIPC);
        c.bsel = (cls != C_R) && (cls != C_BRANCH) && (cls != C_BAD);
        if (cls == C_BRANCH) begin
          c.pc_wr   = taken;
          c.npc_sel = NPC_IMM;
        end
      end
      ST_MEM: begin
        c.dmem_req = 1'b1;
        c.dmem_we  = (cls == C_STORE);
      end
      ST_WB: begin
        c.rf_wr = 1'b1;
        case (cls)
          C_LOAD:  c.wd_sel = WD_MEM;
          C_JAL: begin
            c.wd_sel  = WD_PC;
            c.pc_wr   = 1'b1;
            c.npc_sel = NPC_IMM;
          end
          C_JALR: begin
            c.wd_sel  = WD_PC;
            c.pc_wr   = 1'b1;
            c.npc_sel = NPC_ALU;
          end
          default: c.wd_sel = WD_ALU;
        endcase
      end
      default: c = '0;
    endcase
  end

  assign bus.imem_req = c.imem_req;
  assign bus.dmem_req = c.dmem_req;
  assign bus.dmem_we  = c.dmem_we;
  assign pc_wr        = c.pc_wr;
  assign ir_wr        = c.ir_wr;
  assign rf_wr        = c.rf_wr;
  assign asel         = c.asel;
  assign bsel         = c.bsel;
  assign npc_sel      = c.npc_sel;
  assign wd_sel       = c.wd_sel;
  assign err          = (st == ST_ERR);
  assign state        = st;

  // Retire points: resolved branch, acknowledged store, and every writeback.
  assign retire = ((st == ST_EXEC) && (cls == C_BRANCH)) ||
                  ((st == ST_MEM) && ack && (cls == C_STORE)) ||
                  (st == ST_WB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end
endmodule

// File: tb/tb_riscv_mc_sequencer.sv
// Lockstep bench: each cycle's expected control vector is queued when the stimulus is
// driven and compared against the DUT at the falling edge.
module tb_riscv_mc_sequencer;
  localparam logic [2:0] S_I = 3'd0, S_F = 3'd1, S_D = 3'd2, S_X = 3'd3,
                         S_M = 3'd4, S_W = 3'd5, S_E = 3'd6;

  // f = {imem_req, dmem_req, dmem_we, pc_wr, ir_wr, rf_wr, asel, bsel}
  typedef struct packed {
    logic [2:0] st;
    logic [7:0] f;
    logic [1:0] npc;
    logic [1:0] wd;
    logic       e;
    logic [3:0] ret;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic       zero = 1'b0;
  logic       pc_wr, ir_wr, rf_wr, asel, bsel, err;
  logic [1:0] npc_sel, wd_sel;
  logic [2:0] state;
  logic [3:0] instret;

  riscv_mc_sequencer_if bus ();

  riscv_mc_sequencer #(.MAX_WAIT(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .zero(zero), .bus(bus),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .rf_wr(rf_wr), .asel(asel), .bsel(bsel),
    .npc_sel(npc_sel), .wd_sel(wd_sel), .err(err), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  obs_t       sb[$];
  logic [3:0] exp_ret;
  obs_t       act;

  assign act = {state, bus.imem_req, bus.dmem_req, bus.dmem_we, pc_wr, ir_wr, rf_wr,
                asel, bsel, npc_sel, wd_sel, err, instret};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t o(input logic [2:0] st, input logic [7:0] f,
                             input logic [1:0] npc = 2'b00, input logic [1:0] wd = 2'b00,
                             input logic e = 1'b0);
    return {st, f, npc, wd, e, exp_ret};
  endfunction

  // Called at posedge+1: drive acks, queue expectation, compare at negedge.
  task automatic step(input logic ia, input logic da, input obs_t e, input string tag);
    obs_t x;
    bus.imem_ack = ia;
    bus.dmem_ack = da;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    chk(tag, {12'b0, act}, {12'b0, x});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ok();
    step(1'b1, 1'b0, o(S_F, 8'b1001_1000), "fetch");
  endtask

  task automatic dec();
    step(1'b0, 1'b0, o(S_D, 8'h00), "decode");
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    exp_ret = '0;
    step(1'b1, 1'b1, o(S_I, 8'h00), tag);
    rst = 1'b1;
    step(1'b0, 1'b0, o(S_I, 8'h00), "idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    exp_ret = '0;
    @(posedge clk);
    #1;
    do_reset("reset");

    // ADDI, ack at once; stray acks in EXEC are ignored
    opcode = 7'b0010011;
    fetch_ok(); dec();
    step(1'b1, 1'b1, o(S_X, 8'b0000_0001), "addi_ex");
    step(1'b0, 1'b0, o(S_W, 8'b0000_0100, 2'b00, 2'b01), "addi_wb"); exp_ret++;

    // LW, dmem_ack after 3 wait cycles
    opcode = 7'b0000011;
    fetch_ok(); dec();
    step(1'b0, 1'b0, o(S_X, 8'b0000_0001), "lw_ex");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, o(S_M, 8'b0100_0000), "lw_wait");
    step(1'b0, 1'b1, o(S_M, 8'b0100_0000), "lw_ack");
    step(1'b0, 1'b0, o(S_W, 8'b0000_0100, 2'b00, 2'b10), "lw_wb"); exp_ret++;

    // BNE taken / not taken, BEQ taken
    opcode = 7'b1100011; func3 = 3'b001; zero = 1'b0;
    fetch_ok(); dec();
    step(1'b0, 1'b0, o(S_X, 8'b0001_0010, 2'b01), "bne_taken"); exp_ret++;
    zero = 1'b1;
    fetch_ok(); dec();
    step(1'b0, 1'b0, o(S_X, 8'b0000_0010, 2'b01), "bne_not_taken"); exp_ret++;
    func3 = 3'b000;
    fetch_ok(); dec();
    step(1'b0, 1'b0, o(S_X, 8'b0001_0010, 2'b01), "beq_taken"); exp_ret++;

    // JAL, JALR, R-type
    opcode = 7'b1101111;
    fetch_ok(); dec();
    step(1'b0, 1'b0, o(S_X, 8'b0000_0011), "jal_ex");
    step(1'b0, 1'b0, o(S_W, 8'b0001_0100, 2'b01, 2'b11), "jal_wb"); exp_ret++;
    opcode = 7'b1100111;
    fetch_ok(); dec();
    step(1'b0, 1'b0, o(S_X, 8'b0000_0001), "jalr_ex");
    step(1'b0, 1'b0, o(S_W, 8'b0001_0100, 2'b10, 2'b11), "jalr_wb"); exp_ret++;
    opcode = 7'b0110011;
    fetch_ok(); dec();
    step(1'b0, 1'b0, o(S_X, 8'b0000_0000), "r_ex");
    step(1'b0, 1'b0, o(S_W, 8'b0000_0100, 2'b00, 2'b01), "r_wb"); exp_ret++;

    // SW with dmem_ack held high before the request exists
    opcode = 7'b0100011;
    step(1'b1, 1'b1, o(S_F, 8'b1001_1000), "sw_fetch");
    step(1'b0, 1'b1, o(S_D, 8'h00), "sw_dec_stray_ack");
    step(1'b0, 1'b1, o(S_X, 8'b0000_0001), "sw_ex");
    step(1'b0, 1'b1, o(S_M, 8'b0110_0000), "sw_mem"); exp_ret++;

    // LUI with imem_ack on the 16th request cycle: ack wins over timeout
    opcode = 7'b0110111;
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, o(S_F, 8'b1000_0000), "fetch_wait");
    fetch_ok(); dec();
    step(1'b0, 1'b0, o(S_X, 8'b0000_0001), "lui_ex");
    step(1'b0, 1'b0, o(S_W, 8'b0000_0100, 2'b00, 2'b01), "lui_wb"); exp_ret++;

    // AUIPC
    opcode = 7'b0010111;
    fetch_ok(); dec();
    step(1'b0, 1'b0, o(S_X, 8'b0000_0011), "auipc_ex");
    step(1'b0, 1'b0, o(S_W, 8'b0000_0100, 2'b00, 2'b01), "auipc_wb"); exp_ret++;

    // imem_ack withheld for 16 request cycles -> sticky error
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, o(S_F, 8'b1000_0000), "timeout_wait");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, o(S_E, 8'h00, 2'b00, 2'b00, 1'b1), "err_hold");
    do_reset("reset_after_timeout");

    // Unrecognised opcode -> ERR from DECODE
    opcode = 7'b1111111;
    fetch_ok();
    step(1'b0, 1'b0, o(S_D, 8'h00), "bad_decode");
    step(1'b1, 1'b1, o(S_E, 8'h00, 2'b00, 2'b00, 1'b1), "bad_err");
    step(1'b0, 1'b0, o(S_E, 8'h00, 2'b00, 2'b00, 1'b1), "bad_err_hold");
    do_reset("reset_after_bad");

    // Reset asserted mid-FETCH drops the request without waiting for a clock
    step(1'b0, 1'b0, o(S_F, 8'b1000_0000), "fetch_pre_rst");
    #2 rst = 1'b0;
    #1 chk("async_rst_fetch", {26'b0, state, bus.imem_req, ir_wr, pc_wr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b0, 1'b0, o(S_I, 8'h00), "idle_after_fetch_rst");

    // Reset asserted mid-MEM (store) drops dmem_req/dmem_we
    opcode = 7'b0100011;
    fetch_ok(); dec();
    step(1'b0, 1'b0, o(S_X, 8'b0000_0001), "sw_ex_pre_rst");
    step(1'b0, 1'b0, o(S_M, 8'b0110_0000), "mem_pre_rst");
    #2 rst = 1'b0;
    #1 chk("async_rst_mem", {26'b0, state, bus.dmem_req, bus.dmem_we, instret[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b0, 1'b0, o(S_I, 8'h00), "idle_after_mem_rst");

    // 16 stores: 4-bit counter wraps 15 -> 0
    for (int n = 0; n < 16; n++) begin
      fetch_ok(); dec();
      step(1'b0, 1'b0, o(S_X, 8'b0000_0001), "st_ex");
      step(1'b0, 1'b1, o(S_M, 8'b0110_0000), "st_mem"); exp_ret++;
      if (n == 14) chk("instret_15", {28'b0, instret}, 32'd15);
    end
    step(1'b0, 1'b0, o(S_F, 8'b1000_0000), "fetch_after_wrap");
    chk("instret_wrap", {28'b0, instret}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
